alu_result_framer: RTL and testbench
====================================

// Module: alu_result_framer
// PURPOSE
//  Downstream consumer of the 16-bit ALU. Samples the four registered unit outputs (Arith/Logic/CMP/Shift) and their valid flags.
//  Queues each result, then serializes it as a byte frame over a valid/ready stream to the UART TX path.
//  Frame = [header] + result LSB + result MSB. Decouples single-cycle ALU results from the slow byte-wide transmitter.
// PARAMETERS
//  WIDTH     16  ALU result width; fixed at 16 (two payload bytes)
//  DEPTH     4   result FIFO entries; power of 2, >=2
//  SEND_HDR  1   1: prepend header byte; 0: payload bytes only
// PORTS
//  CLK         in   1   system clock; only clock
//  RST         in   1   synchronous, active-low reset
//  Arith_OUT   in   16  arithmetic result;  Carry_OUT in 1: arithmetic carry
//  Arith_Flag  in   1   Arith_OUT valid this cycle
//  Logic_OUT   in   16  logic result;   Logic_Flag in 1: valid
//  CMP_OUT     in   16  compare result; CMP_Flag   in 1: valid
//  Shift_OUT   in   16  shift result;   Shift_Flag in 1: valid
//  TX_DATA     out  8   byte offered downstream
//  TX_VALID    out  1   TX_DATA valid
//  TX_READY    in   1   downstream accepts byte when TX_VALID & TX_READY at CLK edge
//  BUSY        out  1   FSM not IDLE or FIFO non-empty
//  OVF         out  1   sticky: a result was dropped because the FIFO was full
//  COLL        out  1   sticky: more than one unit flag high in one cycle
// BEHAVIOUR
//  Reset (RST=0 at edge): FIFO emptied, FSM->IDLE; TX_DATA=0, TX_VALID=0, BUSY=0, OVF=0, COLL=0. Mid-frame reset aborts the frame; no bytes resume.
//  Capture: at each edge where any flag=1, push entry {unit_id[1:0], carry, result[15:0]}; carry = Carry_OUT for arith, else 0.
//  Unit priority when several flags high: Arith(00) > Logic(01) > CMP(10) > Shift(11); only the winner is pushed; COLL set.
//  FIFO: full & push & no pop -> entry dropped, OVF set, contents unchanged.
//    Full & push & pop same edge -> both performed, no OVF. Empty & push & pop cannot occur (pop needs a head entry).
//  FSM states: IDLE, HDR, LSB, MSB.
//    IDLE: FIFO non-empty -> HDR (SEND_HDR=1) or LSB (SEND_HDR=0); load TX_DATA from head, TX_VALID=1.
//    HDR: TX_DATA = {2'b10, unit_id, carry, 3'b000}; on accept -> LSB.
//    LSB: TX_DATA = result[7:0]; on accept -> MSB.
//    MSB: TX_DATA = result[15:8]; on accept pop head; if FIFO still holds another entry -> first state of next frame, TX_VALID stays 1 (back-to-back).
//      Otherwise -> IDLE, TX_VALID=0.
//  TX_DATA and TX_VALID are registered; they hold stable while TX_VALID=1 & TX_READY=0. TX_VALID never drops without a handshake.
//  Latency: flag high at edge E0 -> entry written at E0; TX_VALID=1 after E1 (FSM idle). TX_READY tied 1: 3-byte frame in 3 cycles.
//  Head entry stays in FIFO until MSB accepted (count includes in-flight frame).
//  BUSY is combinational from registered state: (state!=IDLE) | ~empty.
//  Pointers: log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ & rest equal.
// STRUCTURE
//  Shared package alu_out_pkg: UNIT_ARITH/LOGIC/CMP/SHIFT ids, HDR_TAG=2'b10, FSM state encoding, entry width (19).
//  Sub-module alu_res_fifo: sync FIFO, params DW=19, DEPTH; ports CLK, RST, wr_en, wr_data, rd_en, rd_data, full, empty.
//  Top: priority encoder + sticky flags + 4-state serializer FSM.
// TESTING
//  Reset: drive flags, assert RST=0 for 2 cycles mid-frame -> TX_VALID=0, OVF=0, COLL=0, BUSY=0 next cycle; no stale bytes after release.
//  Single arith: Arith_OUT=16'h12F0, Carry_OUT=1, Arith_Flag for 1 cycle, TX_READY=1.
//    -> bytes 8'h88, 8'hF0, 8'h12 on consecutive cycles; TX_VALID rises after E1.
//  Backpressure: Shift_OUT=16'hBEEF, hold TX_READY=0 for 5 cycles after TX_VALID -> TX_DATA stays 8'hB0.
//    Then with TX_READY=1 -> 8'hEF, 8'hBE.
//  Collision: Logic_Flag=1 & CMP_Flag=1, Logic_OUT=16'h00AA -> only frame 8'h90,8'hAA,8'h00; COLL=1 until reset.
//  Overflow: TX_READY=0, push 6 CMP results 1..6 (DEPTH=4) -> OVF=1.
//    Release -> frames for 1..4 only, back-to-back with TX_VALID continuously 1.
//  Full push+pop: FIFO full, MSB accepted on the same edge as a new Arith_Flag -> no OVF; new result framed last.

Source files
------------

// File: rtl/alu_out_pkg.sv
// Shared definitions for the ALU result framer: unit ids, header tag,
// serializer state encoding and the queued result entry layout.
package alu_out_pkg;

    localparam int ENTRY_W = 19;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam logic [1:0] HDR_TAG = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_LSB  = 2'b10,
        ST_MSB  = 2'b11
    } state_t;

    typedef struct packed {
        logic [1:0]  unit_id;
        logic        carry;
        logic [15:0] result;
    } entry_t;

    function automatic logic [7:0] hdr_byte(entry_t e);
        return {HDR_TAG, e.unit_id, e.carry, 3'b000};
    endfunction

endpackage

// File: rtl/alu_result_framer_if.sv
// Byte stream towards the UART TX path: valid/ready handshake with one data byte.
interface alu_result_framer_if;

    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);

endinterface

// File: rtl/alu_res_fifo.sv
// Synchronous result FIFO with wrap-bit pointers; also exposes the entry
// behind the head so the framer can start the next frame without a gap.
module alu_res_fifo #(
    parameter int DW    = 19,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic [DW-1:0]            rd_data_nxt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A write into a full FIFO is only allowed when the head leaves on the same edge.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data     = mem[rd_ptr[AW-1:0]];
    assign rd_data_nxt = mem[rd_ptr[AW-1:0] + AW'(1)];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_result_framer.sv
// Captures ALU unit results by priority, queues them and streams each as a
// byte frame (optional header, result LSB, result MSB) over a valid/ready port.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | nothing offered; start a frame once the FIFO has an entry
//   ST_HDR  | offering header {tag, unit_id, carry, 000}
//   ST_LSB  | offering result[7:0]
//   ST_MSB  | offering result[15:8]; head is popped when it is accepted
module alu_result_framer
    import alu_out_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int SEND_HDR = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  Arith_OUT,
    input  logic              Carry_OUT,
    input  logic              Arith_Flag,
    input  logic [WIDTH-1:0]  Logic_OUT,
    input  logic              Logic_Flag,
    input  logic [WIDTH-1:0]  CMP_OUT,
    input  logic              CMP_Flag,
    input  logic [WIDTH-1:0]  Shift_OUT,
    input  logic              Shift_Flag,
    alu_result_framer_if.master tx,
    output logic              BUSY,
    output logic              OVF,
    output logic              COLL
);

    localparam int     CW       = $clog2(DEPTH) + 1;
    localparam state_t FIRST_ST = (SEND_HDR != 0) ? ST_HDR : ST_LSB;

    state_t         state;
    logic [7:0]     tx_data_q;
    logic           tx_valid_q;
    logic           ovf_q;
    logic           coll_q;

    entry_t         push_entry;
    entry_t         head;
    entry_t         head_nxt;
    logic           push;
    logic           pop;
    logic           tx_accept;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    function automatic logic [7:0] first_byte(entry_t e);
        return (SEND_HDR != 0) ? hdr_byte(e) : e.result[7:0];
    endfunction

    always_comb begin
        push_entry = '0;
        if (Arith_Flag)
            push_entry = '{unit_id: UNIT_ARITH, carry: Carry_OUT, result: Arith_OUT};
        else if (Logic_Flag)
            push_entry = '{unit_id: UNIT_LOGIC, carry: 1'b0, result: Logic_OUT};
        else if (CMP_Flag)
            push_entry = '{unit_id: UNIT_CMP, carry: 1'b0, result: CMP_OUT};
        else if (Shift_Flag)
            push_entry = '{unit_id: UNIT_SHIFT, carry: 1'b0, result: Shift_OUT};
    end

    assign push      = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
    assign tx_accept = tx_valid_q & tx.TX_READY;
    assign pop       = (state == ST_MSB) & tx_accept;

    alu_res_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .wr_en       (push),
        .wr_data     (push_entry),
        .rd_en       (pop),
        .rd_data     (head),
        .rd_data_nxt (head_nxt),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
            if ($countones({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}) > 1) coll_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= FIRST_ST;
                        tx_data_q  <= first_byte(head);
                        tx_valid_q <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (tx_accept) begin
                        state     <= ST_LSB;
                        tx_data_q <= head.result[7:0];
                    end
                end
                ST_LSB: begin
                    if (tx_accept) begin
                        state     <= ST_MSB;
                        tx_data_q <= head.result[15:8];
                    end
                end
                ST_MSB: begin
                    // Next frame comes from behind the head, or from the entry landing this edge.
                    if (tx_accept) begin
                        if (fifo_count > CW'(1)) begin
                            state     <= FIRST_ST;
                            tx_data_q <= first_byte(head_nxt);
                        end else if (push) begin
                            state     <= FIRST_ST;
                            tx_data_q <= first_byte(push_entry);
                        end else begin
                            state      <= ST_IDLE;
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx.TX_DATA  = tx_data_q;
    assign tx.TX_VALID = tx_valid_q;
    assign BUSY        = (state != ST_IDLE) | ~fifo_empty;
    assign OVF         = ovf_q;
    assign COLL        = coll_q;

endmodule

// File: tb/tb_alu_result_framer.sv
// Self-checking bench for alu_result_framer: queue-level reference model
// compared every cycle, plus directed frames with literal byte expectations.
module tb_alu_result_framer;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, Shift_OUT = '0;
    logic        Carry_OUT = 1'b0;
    logic        Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
    logic        BUSY, OVF, COLL;

    alu_result_framer_if txif();

    alu_result_framer #(.WIDTH(16), .DEPTH(DEPTH), .SEND_HDR(1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .Shift_OUT  (Shift_OUT),
        .Shift_Flag (Shift_Flag),
        .tx         (txif),
        .BUSY       (BUSY),
        .OVF        (OVF),
        .COLL       (COLL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  unit_id;
        logic        carry;
        logic [15:0] result;
    } m_ent;

    m_ent       mq[$];
    logic [7:0] acc_log[$];
    int         k = 0;
    bit         m_ovf = 0, m_coll = 0, fresh = 0, checking = 0;
    int         checks = 0, errors = 0;

    function automatic logic [7:0] fbyte(m_ent e, int idx);
        case (idx)
            0:       return {2'b10, e.unit_id, e.carry, 3'b000};
            1:       return e.result[7:0];
            default: return e.result[15:8];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated between edges, predicts the effect of the next edge.
    always @(negedge CLK) begin
        bit   exp_v;
        bit   pop;
        bit   had;
        int   n;
        m_ent e;
        exp_v = (mq.size() != 0) && !fresh;
        if (checking) begin
            chk("tx_valid", 32'(txif.TX_VALID), 32'(exp_v));
            if (exp_v) chk("tx_data", 32'(txif.TX_DATA), 32'(fbyte(mq[0], k)));
            chk("busy", 32'(BUSY), 32'(mq.size() != 0));
            chk("ovf", 32'(OVF), 32'(m_ovf));
            chk("coll", 32'(COLL), 32'(m_coll));
        end
        if (!RST) begin
            mq.delete();
            k = 0; m_ovf = 0; m_coll = 0; fresh = 0;
        end else begin
            if (txif.TX_VALID === 1'b1 && txif.TX_READY === 1'b1) acc_log.push_back(txif.TX_DATA);
            pop = 0;
            had = (mq.size() != 0);
            if (exp_v && txif.TX_READY) begin
                if (k == 2) begin pop = 1; k = 0; end
                else k++;
            end
            n = int'(Arith_Flag) + int'(Logic_Flag) + int'(CMP_Flag) + int'(Shift_Flag);
            if (pop) void'(mq.pop_front());
            if (n > 0) begin
                if (Arith_Flag)      e = '{2'd0, Carry_OUT, Arith_OUT};
                else if (Logic_Flag) e = '{2'd1, 1'b0, Logic_OUT};
                else if (CMP_Flag)   e = '{2'd2, 1'b0, CMP_OUT};
                else                 e = '{2'd3, 1'b0, Shift_OUT};
                if (mq.size() < DEPTH) mq.push_back(e);
                else m_ovf = 1;
                if (n > 1) m_coll = 1;
            end
            fresh = !had && (mq.size() != 0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_flags();
        Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0; Carry_OUT = 0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 10; i++) begin
            if (txif.TX_VALID === 1'b1) break;
            step();
        end
        chk(name, 32'(txif.TX_VALID), 32'd1);
    endtask

    task automatic chk_log(input string name, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        chk({name, "_len"}, 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            chk({name, "_b0"}, 32'(acc_log[0]), 32'(b0));
            chk({name, "_b1"}, 32'(acc_log[1]), 32'(b1));
            chk({name, "_b2"}, 32'(acc_log[2]), 32'(b2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual running expected finished");
        $fatal(1);
    end

    initial begin
        txif.TX_READY = 1'b0;
        RST = 0;
        step(); step();
        RST = 1;
        checking = 1;
        chk("rst_valid", 32'(txif.TX_VALID), 32'd0);
        chk("rst_data", 32'(txif.TX_DATA), 32'd0);

        // Single arith result, ready tied high
        txif.TX_READY = 1;
        acc_log.delete();
        Arith_OUT = 16'h12F0; Carry_OUT = 1; Arith_Flag = 1;
        step();
        clr_flags();
        chk("single_e0_valid", 32'(txif.TX_VALID), 32'd0);
        step();
        chk("single_e1_valid", 32'(txif.TX_VALID), 32'd1);
        chk("single_e1_data", 32'(txif.TX_DATA), 32'h88);
        step(); step(); step();
        chk_log("single", 8'h88, 8'hF0, 8'h12);
        chk("single_busy", 32'(BUSY), 32'd0);

        // Backpressure on header
        txif.TX_READY = 0;
        acc_log.delete();
        Shift_OUT = 16'hBEEF; Shift_Flag = 1;
        step();
        clr_flags();
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", 32'(txif.TX_DATA), 32'hB0);
            step();
        end
        txif.TX_READY = 1;
        step(); step(); step();
        chk_log("bp", 8'hB0, 8'hEF, 8'hBE);

        // Collision: logic wins over cmp
        acc_log.delete();
        Logic_OUT = 16'h00AA; CMP_OUT = 16'h1234; Logic_Flag = 1; CMP_Flag = 1;
        step();
        clr_flags();
        for (int i = 0; i < 5; i++) step();
        chk_log("coll", 8'h90, 8'hAA, 8'h00);
        chk("coll_sticky", 32'(COLL), 32'd1);

        // Overflow: six pushes into a four-entry FIFO while stalled
        txif.TX_READY = 0;
        acc_log.delete();
        for (int i = 1; i <= 6; i++) begin
            CMP_OUT = 16'(i); CMP_Flag = 1;
            step();
        end
        clr_flags();
        chk("ovf_set", 32'(OVF), 32'd1);
        txif.TX_READY = 1;
        for (int i = 0; i < 12; i++) step();
        chk("ovf_len", 32'(acc_log.size()), 32'd12);
        if (acc_log.size() == 12) begin
            for (int i = 0; i < 4; i++) begin
                chk("ovf_hdr", 32'(acc_log[3*i]), 32'hA0);
                chk("ovf_lsb", 32'(acc_log[3*i+1]), 32'(i + 1));
                chk("ovf_msb", 32'(acc_log[3*i+2]), 32'h00);
            end
        end
        chk("ovf_busy", 32'(BUSY), 32'd0);

        // Mid-frame reset with flags active
        acc_log.delete();
        Arith_OUT = 16'h0F0F; Arith_Flag = 1;
        step();
        clr_flags();
        wait_valid("mrst_valid");
        step();
        RST = 0; Logic_Flag = 1; Logic_OUT = 16'h5A5A;
        step();
        chk("mrst_valid0", 32'(txif.TX_VALID), 32'd0);
        chk("mrst_busy0", 32'(BUSY), 32'd0);
        chk("mrst_ovf0", 32'(OVF), 32'd0);
        chk("mrst_coll0", 32'(COLL), 32'd0);
        step();
        RST = 1; clr_flags();
        acc_log.delete();
        for (int i = 0; i < 6; i++) step();
        chk("mrst_no_stale", 32'(acc_log.size()), 32'd0);

        // Full FIFO: MSB accept and new push on the same edge
        txif.TX_READY = 0;
        acc_log.delete();
        for (int i = 0; i < 4; i++) begin
            CMP_OUT = 16'(8'h11 + i); CMP_Flag = 1;
            step();
        end
        clr_flags();
        txif.TX_READY = 1;
        step(); step();
        Arith_OUT = 16'h5555; Carry_OUT = 0; Arith_Flag = 1;
        step();
        clr_flags();
        for (int i = 0; i < 30 && BUSY === 1'b1; i++) step();
        chk("fpp_ovf", 32'(OVF), 32'd0);
        chk("fpp_len", 32'(acc_log.size()), 32'd15);
        if (acc_log.size() == 15) begin
            chk("fpp_hdr", 32'(acc_log[12]), 32'h80);
            chk("fpp_lsb", 32'(acc_log[13]), 32'h55);
            chk("fpp_msb", 32'(acc_log[14]), 32'h55);
        end

        // Randomized traffic with backpressure and occasional reset
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] f;
            Arith_OUT = 16'($urandom); Logic_OUT = 16'($urandom);
            CMP_OUT   = 16'($urandom); Shift_OUT = 16'($urandom);
            Carry_OUT = 1'($urandom);
            f = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = f;
            txif.TX_READY = ($urandom_range(0, 3) != 0);
            RST = ($urandom_range(0, 199) != 0);
            step();
        end
        clr_flags();
        RST = 1;
        txif.TX_READY = 1;
        for (int i = 0; i < 40; i++) step();
        chk("final_busy", 32'(BUSY), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
